// File: rtl/chiplet_types_pkg.sv
// Shared address map, status codes and state encoding for the endpoint message loader.
// Every endpoint register access in the loader goes through these constants.
package chiplet_types_pkg;

   localparam logic [31:0] PKT_ID_ADDR         = 32'h0000_0000;
   localparam logic [31:0] TX_SEND_ADDR        = 32'h0000_1004;
   localparam logic [31:0] TX_CACHE_START_ADDR = 32'h0000_2000;

   typedef enum logic [1:0] {
      LDR_OK      = 2'd0,
      LDR_BAD_CMD = 2'd1,
      LDR_BUS_ERR = 2'd2
   } loader_status_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PTR,
      ST_SEND
   } loader_state_t;

   // Byte address of TX cache word idx.
   function automatic logic [31:0] cache_word_addr(input logic [8:0] idx);
      return TX_CACHE_START_ADDR + {21'b0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/bus_req_hold.sv
// Single outstanding peripheral-bus write request, held stable until the endpoint
// stops stalling; reports the completing cycle and whether it returned an error.
module bus_req_hold (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        issue,
   input  logic [31:0] issue_addr,
   input  logic [31:0] issue_wdata,
   input  logic        bus_request_stall,
   input  logic        bus_error,
   output logic        bus_wen,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_strobe,
   output logic        complete,
   output logic        error
);

   assign complete = bus_wen && !bus_request_stall;
   assign error    = complete && bus_error;

   // A new issue may overwrite the request only in the cycle the old one completes.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         bus_wen    <= 1'b0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         bus_strobe <= '0;
      end else if (issue) begin
         bus_wen    <= 1'b1;
         bus_addr   <= issue_addr;
         bus_wdata  <= issue_wdata;
         bus_strobe <= 4'hF;
      end else if (complete) begin
         bus_wen    <= 1'b0;
      end
   end

endmodule

// File: rtl/endpoint_msg_loader.sv
// Loads one message into the endpoint TX cache, programs its packet-start pointer
// and fires it through the send register; one command at a time.
module endpoint_msg_loader
   import chiplet_types_pkg::*;
#(
   parameter  int NUM_MSGS        = 4,
   parameter  int CACHE_NUM_WORDS = 128,
   localparam int IDW             = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1
) (
   input  logic           clk,
   input  logic           n_rst,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [IDW-1:0] cmd_msg_id,
   input  logic [6:0]     cmd_start_word,
   input  logic [7:0]     cmd_len,
   input  logic           data_valid,
   output logic           data_ready,
   input  logic [31:0]    data_word,
   output logic           done,
   output logic [1:0]     status,
   output logic           bus_wen,
   output logic           bus_ren,
   output logic [31:0]    bus_addr,
   output logic [31:0]    bus_wdata,
   output logic [3:0]     bus_strobe,
   input  logic [31:0]    bus_rdata,
   input  logic           bus_error,
   input  logic           bus_request_stall
);

   loader_state_t  state, state_next;
   loader_status_t status_q, finish_status;
   logic [IDW-1:0] msg_id;
   logic [6:0]     start_word;
   logic [7:0]     len;
   logic [7:0]     issued;
   logic [7:0]     written;
   logic           finish, accept_cmd, data_fire;
   logic           issue, req_complete, req_error;
   logic [31:0]    issue_addr, issue_wdata;
   logic [8:0]     end_sum;
   logic           cmd_bad;
   logic           unused_bus_rdata;

   assign unused_bus_rdata = ^bus_rdata;
   assign bus_ren          = 1'b0;
   assign status           = status_q;
   assign end_sum          = {2'b0, cmd_start_word} + {1'b0, cmd_len};
   assign cmd_bad          = (cmd_len == 8'd0) || (end_sum > 9'(CACHE_NUM_WORDS));
   assign data_fire        = data_valid && data_ready;

   // Request register doubles as the one-word holding register during LOAD.
   bus_req_hold u_req (
      .clk               (clk),
      .n_rst             (n_rst),
      .issue             (issue),
      .issue_addr        (issue_addr),
      .issue_wdata       (issue_wdata),
      .bus_request_stall (bus_request_stall),
      .bus_error         (bus_error),
      .bus_wen           (bus_wen),
      .bus_addr          (bus_addr),
      .bus_wdata         (bus_wdata),
      .bus_strobe        (bus_strobe),
      .complete          (req_complete),
      .error             (req_error)
   );

   always_comb begin
      state_next    = state;
      finish        = 1'b0;
      finish_status = LDR_OK;
      accept_cmd    = 1'b0;
      issue         = 1'b0;
      issue_addr    = '0;
      issue_wdata   = '0;
      data_ready    = 1'b0;
      cmd_ready     = (state == ST_IDLE) && !done;
      case (state)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               accept_cmd = 1'b1;
               if (cmd_bad) begin
                  finish        = 1'b1;
                  finish_status = LDR_BAD_CMD;
               end else begin
                  state_next = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            data_ready = (issued < len) && (!bus_wen || req_complete);
            if (req_error) begin
               state_next    = ST_IDLE;
               finish        = 1'b1;
               finish_status = LDR_BUS_ERR;
            end else if (req_complete && (written + 8'd1 == len)) begin
               state_next  = ST_PTR;
               issue       = 1'b1;
               issue_addr  = PKT_ID_ADDR + 32'({msg_id, 2'b00});
               issue_wdata = {23'b0, start_word, 2'b00};
            end else if (data_fire) begin
               issue       = 1'b1;
               issue_addr  = cache_word_addr({2'b0, start_word} + {1'b0, issued});
               issue_wdata = data_word;
            end
         end
         ST_PTR: begin
            if (req_error) begin
               state_next    = ST_IDLE;
               finish        = 1'b1;
               finish_status = LDR_BUS_ERR;
            end else if (req_complete) begin
               state_next  = ST_SEND;
               issue       = 1'b1;
               issue_addr  = TX_SEND_ADDR;
               issue_wdata = 32'(msg_id);
            end
         end
         ST_SEND: begin
            if (req_complete) begin
               state_next    = ST_IDLE;
               finish        = 1'b1;
               finish_status = req_error ? LDR_BUS_ERR : LDR_OK;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= ST_IDLE;
         status_q   <= LDR_OK;
         done       <= 1'b0;
         msg_id     <= '0;
         start_word <= '0;
         len        <= '0;
         issued     <= '0;
         written    <= '0;
      end else begin
         state <= state_next;
         done  <= finish;
         if (finish)
            status_q <= finish_status;
         if (accept_cmd) begin
            msg_id     <= cmd_msg_id;
            start_word <= cmd_start_word;
            len        <= cmd_len;
            issued     <= '0;
            written    <= '0;
         end else if (state == ST_LOAD) begin
            if (data_fire)
               issued <= issued + 8'd1;
            if (req_complete)
               written <= written + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_endpoint_msg_loader.sv
// Directed bench for endpoint_msg_loader: scripted commands with hand-computed bus
// writes, done timing and status, including stall, bad command, error and reset cases.
module tb_endpoint_msg_loader;
   import chiplet_types_pkg::*;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_msg_id = '0;
   logic [6:0]  cmd_start_word = '0;
   logic [7:0]  cmd_len = '0;
   logic        data_valid = 1'b0;
   logic        data_ready;
   logic [31:0] data_word = '0;
   logic        done;
   logic [1:0]  status;
   logic        bus_wen, bus_ren;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_strobe;
   logic [31:0] bus_rdata = '0;
   logic        bus_error = 1'b0;
   logic        bus_request_stall = 1'b0;

   int checks = 0;
   int passes = 0;
   logic [31:0] words[$];
   logic [31:0] log_addr[$], log_data[$];
   logic [31:0] exp_addr[$], exp_data[$];
   int   done_cycle;
   logic [1:0] done_status;
   logic done_cmd_ready, done_wen;
   int   hold_errs, unstable;
   bit   wen_seen;

   endpoint_msg_loader #(.NUM_MSGS(4), .CACHE_NUM_WORDS(128)) dut (
      .clk               (clk),
      .n_rst             (n_rst),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_msg_id        (cmd_msg_id),
      .cmd_start_word    (cmd_start_word),
      .cmd_len           (cmd_len),
      .data_valid        (data_valid),
      .data_ready        (data_ready),
      .data_word         (data_word),
      .done              (done),
      .status            (status),
      .bus_wen           (bus_wen),
      .bus_ren           (bus_ren),
      .bus_addr          (bus_addr),
      .bus_wdata         (bus_wdata),
      .bus_strobe        (bus_strobe),
      .bus_rdata         (bus_rdata),
      .bus_error         (bus_error),
      .bus_request_stall (bus_request_stall)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed === expected)
         passes++;
      else
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
   endtask

   task automatic checkWrites(input string tag);
      checkOutput({tag, "_count"}, 32'(log_addr.size()), 32'(exp_addr.size()));
      for (int i = 0; i < log_addr.size() && i < exp_addr.size(); i++) begin
         checkOutput($sformatf("%s_addr%0d", tag, i), log_addr[i], exp_addr[i]);
         checkOutput($sformatf("%s_data%0d", tag, i), log_data[i], exp_data[i]);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      checkOutput({tag, "_data_ready"}, 32'(data_ready), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_status"}, 32'(status), 32'd0);
      checkOutput({tag, "_wen"}, 32'(bus_wen), 32'd0);
      checkOutput({tag, "_ren"}, 32'(bus_ren), 32'd0);
      checkOutput({tag, "_addr"}, bus_addr, 32'd0);
      checkOutput({tag, "_wdata"}, bus_wdata, 32'd0);
      checkOutput({tag, "_strobe"}, 32'(bus_strobe), 32'd0);
   endtask

   // One command, cycle by cycle at the falling edge: stall each request stall_cycles
   // cycles, flag bus_error on write err_write, optionally reset once ptr_addr appears.
   task automatic applyStimulus(input logic [1:0] id, input logic [6:0] start, input logic [7:0] len,
                                input int stall_cycles, input int err_write,
                                input bit rst_at_ptr, input logic [31:0] ptr_addr);
      int word_idx, wr_idx, age, c;
      bit prev_wen, prev_complete, complete, finished;
      logic [31:0] held_addr, held_data;
      log_addr.delete();
      log_data.delete();
      done_cycle = -1;
      hold_errs = 0;
      unstable = 0;
      wen_seen = 0;
      word_idx = 0; wr_idx = 0; age = 0;
      prev_wen = 0; prev_complete = 0; finished = 0;
      held_addr = '0; held_data = '0;
      @(negedge clk);
      cmd_msg_id = id;
      cmd_start_word = start;
      cmd_len = len;
      cmd_valid = 1'b1;
      #1 checkOutput("cmd_ready_at_accept", 32'(cmd_ready), 32'd1);
      for (c = 0; c < 200 && !finished; c++) begin
         if (c > 0) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (done) begin
               done_cycle = c;
               done_status = status;
               done_cmd_ready = cmd_ready;
               done_wen = bus_wen;
               finished = 1;
            end
         end
         if (!finished) begin
            if (bus_wen) begin
               wen_seen = 1;
               if (!prev_wen || prev_complete) begin
                  age = 0;
                  held_addr = bus_addr;
                  held_data = bus_wdata;
               end else begin
                  age++;
                  if (bus_addr !== held_addr || bus_wdata !== held_data) unstable++;
               end
            end
            if (rst_at_ptr && bus_wen && bus_addr == ptr_addr) begin
               n_rst = 1'b0;
               #1 checkResetOutputs("midreset");
               finished = 1;
               @(negedge clk);
               n_rst = 1'b1;
            end else begin
               bus_request_stall = bus_wen && (age < stall_cycles);
               complete = bus_wen && !bus_request_stall;
               bus_error = complete && (wr_idx == err_write);
               data_valid = (word_idx < int'(len)) && (word_idx < words.size());
               data_word = data_valid ? words[word_idx] : 32'd0;
               #1;
               if (complete) begin
                  log_addr.push_back(bus_addr);
                  log_data.push_back(bus_wdata);
                  checkOutput("strobe", 32'(bus_strobe), 32'hF);
                  if (age != stall_cycles) hold_errs++;
                  wr_idx++;
               end
               if (data_valid && data_ready) word_idx++;
               prev_wen = bus_wen;
               prev_complete = complete;
            end
         end
      end
      data_valid = 1'b0;
      bus_request_stall = 1'b0;
      bus_error = 1'b0;
      cmd_valid = 1'b0;
      checkOutput("cmd_finished", 32'(finished), 32'd1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      checkResetOutputs("reset");
      n_rst = 1'b1;

      // Basic 3-word load, no stall.
      words = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
      applyStimulus(2'd2, 7'd4, 8'd3, 0, -1, 0, 32'd0);
      exp_addr = '{32'h2010, 32'h2014, 32'h2018, 32'h0008, 32'h1004};
      exp_data = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'h10, 32'h2};
      checkWrites("basic");
      checkOutput("basic_done_cycle", 32'(done_cycle), 32'd7);
      checkOutput("basic_status", 32'(done_status), 32'(LDR_OK));
      checkOutput("basic_ready_during_done", 32'(done_cmd_ready), 32'd0);

      // Same command with two stall cycles per write.
      applyStimulus(2'd2, 7'd4, 8'd3, 2, -1, 0, 32'd0);
      checkWrites("stall");
      checkOutput("stall_done_cycle", 32'(done_cycle), 32'd17);
      checkOutput("stall_status", 32'(done_status), 32'(LDR_OK));
      checkOutput("stall_hold_len", 32'(hold_errs), 32'd0);
      checkOutput("stall_stable", 32'(unstable), 32'd0);

      // Illegal commands: zero length, then overrun past the cache end.
      applyStimulus(2'd1, 7'd0, 8'd0, 0, -1, 0, 32'd0);
      checkOutput("len0_done_cycle", 32'(done_cycle), 32'd1);
      checkOutput("len0_status", 32'(done_status), 32'(LDR_BAD_CMD));
      checkOutput("len0_no_bus", 32'(wen_seen), 32'd0);
      applyStimulus(2'd1, 7'd120, 8'd9, 0, -1, 0, 32'd0);
      checkOutput("overrun_done_cycle", 32'(done_cycle), 32'd1);
      checkOutput("overrun_status", 32'(done_status), 32'(LDR_BAD_CMD));
      checkOutput("overrun_no_bus", 32'(wen_seen), 32'd0);

      // Last cache word.
      words = '{32'hDDDD_0004};
      applyStimulus(2'd0, 7'd127, 8'd1, 0, -1, 0, 32'd0);
      exp_addr = '{32'h21FC, 32'h0000, 32'h1004};
      exp_data = '{32'hDDDD_0004, 32'h1FC, 32'h0};
      checkWrites("boundary");
      checkOutput("boundary_done_cycle", 32'(done_cycle), 32'd5);
      checkOutput("boundary_status", 32'(done_status), 32'(LDR_OK));

      // Bus error on the second data write.
      words = '{32'hEEEE_0005, 32'hFFFF_0006, 32'h1111_0007, 32'h2222_0008};
      applyStimulus(2'd1, 7'd0, 8'd4, 0, 1, 0, 32'd0);
      exp_addr = '{32'h2000, 32'h2004};
      exp_data = '{32'hEEEE_0005, 32'hFFFF_0006};
      checkWrites("buserr");
      checkOutput("buserr_done_cycle", 32'(done_cycle), 32'd4);
      checkOutput("buserr_status", 32'(done_status), 32'(LDR_BUS_ERR));
      checkOutput("buserr_wen_at_done", 32'(done_wen), 32'd0);

      // Reset while the pointer write is on the bus, then a clean rerun.
      words = '{32'h3333_0009, 32'h4444_000A};
      applyStimulus(2'd3, 7'd10, 8'd2, 0, -1, 1, 32'h0000_000C);
      exp_addr = '{32'h2028, 32'h202C};
      exp_data = '{32'h3333_0009, 32'h4444_000A};
      checkWrites("midreset");
      checkOutput("midreset_no_done", 32'(done_cycle), 32'hFFFF_FFFF);
      applyStimulus(2'd3, 7'd10, 8'd2, 0, -1, 0, 32'd0);
      exp_addr = '{32'h2028, 32'h202C, 32'h000C, 32'h1004};
      exp_data = '{32'h3333_0009, 32'h4444_000A, 32'h28, 32'h3};
      checkWrites("afterreset");
      checkOutput("afterreset_done_cycle", 32'(done_cycle), 32'd6);
      checkOutput("afterreset_status", 32'(done_status), 32'(LDR_OK));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
